// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit: funct3 branch encodings,
// 2-bit BHT counter values, FSM states and the saturating counter update.
package branch_resolve_unit_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } bru_state_e;

  function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
    if (taken) begin
      return (ctr == ST) ? ST : ctr + 2'd1;
    end
    return (ctr == SNT) ? SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_bht_2bit.sv
// Bimodal history table of 2-bit saturating counters with one combinational
// read port and one clocked write port; a same-index read sees the old value.
module bht_2bit
  import branch_resolve_unit_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [$clog2(DEPTH)-1:0] rd_idx_i,
  output logic [1:0]               rd_ctr_o,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] wr_idx_i,
  input  logic                     wr_taken_i
);

  logic [1:0] ctr_q [DEPTH];
  logic [1:0] wr_ctr_d;

  assign rd_ctr_o = ctr_q[rd_idx_i];
  assign wr_ctr_d = ctr_update(ctr_q[wr_idx_i], wr_taken_i);

  // Every counter restarts weakly not-taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctr_q[i] <= WNT;
      end
    end else if (we_i) begin
      ctr_q[wr_idx_i] <= wr_ctr_d;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves branches/jumps at EX, trains the BHT and holds a registered redirect
// until fetch accepts it. Define BRU_STATS_EN to add branch/mispredict counters.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 64,
  parameter int ROB_IDX_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [XLEN-1:0]      fetch_pc,
  output logic                 fetch_pred_tk,
  input  logic                 ex_valid,
  input  logic                 ex_jump,
  input  logic                 ex_branch,
  input  logic [2:0]           ex_funct3,
  input  logic                 ex_zero,
  input  logic                 ex_neg,
  input  logic                 ex_carry,
  input  logic [XLEN-1:0]      ex_alu_result,
  input  logic [XLEN-1:0]      ex_pc,
  input  logic [XLEN-1:0]      ex_imm,
  input  logic                 ex_pred_tk,
  input  logic [XLEN-1:0]      ex_pred_tgt,
  input  logic [ROB_IDX_W-1:0] ex_rob_idx,
  input  logic [ROB_IDX_W-1:0] rob_head,
  output logic                 redir_valid,
  input  logic                 redir_ready,
  output logic [XLEN-1:0]      redir_pc,
  output logic [ROB_IDX_W-1:0] redir_rob_idx,
  output logic                 if_id_flush
`ifdef BRU_STATS_EN
  ,
  output logic [31:0]          stat_branches,
  output logic [31:0]          stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(DEPTH);

  bru_state_e           state_q;
  logic                 redir_valid_q;
  logic [XLEN-1:0]      redir_pc_q;
  logic [ROB_IDX_W-1:0] redir_rob_idx_q;

  logic                 cond_tk;
  logic                 is_ctl;
  logic                 actual_tk;
  logic [XLEN-1:0]      target;
  logic                 mispredict;
  logic [XLEN-1:0]      redir_pc_d;
  logic [ROB_IDX_W-1:0] new_age;
  logic [ROB_IDX_W-1:0] pend_age;
  logic                 handshake;
  logic                 bht_we;
  logic [1:0]           fetch_ctr;
  logic                 unused_pc_bits;

  always_comb begin
    cond_tk = 1'b0;
    case (ex_funct3)
      F3_BEQ:  cond_tk = ex_zero;
      F3_BNE:  cond_tk = ~ex_zero;
      F3_BLT:  cond_tk = ex_neg;
      F3_BGE:  cond_tk = ~ex_neg;
      F3_BLTU: cond_tk = ex_carry;
      F3_BGEU: cond_tk = ~ex_carry;
      default: cond_tk = 1'b0;
    endcase
  end

  assign is_ctl     = ex_valid & (ex_jump | ex_branch);
  assign target     = ex_jump ? (ex_alu_result & ~XLEN'(1)) : (ex_pc + ex_imm);
  assign actual_tk  = ex_jump | cond_tk;
  assign mispredict = is_ctl & ((actual_tk != ex_pred_tk) | (actual_tk & (target != ex_pred_tgt)));
  assign redir_pc_d = actual_tk ? target : (ex_pc + XLEN'(4));

  // Modular distance from the ROB head orders slots correctly across the wrap.
  assign new_age   = ex_rob_idx - rob_head;
  assign pend_age  = redir_rob_idx_q - rob_head;
  assign handshake = redir_valid_q & redir_ready;
  assign bht_we    = ex_valid & ex_branch & ~ex_jump;

  bht_2bit #(
    .DEPTH(DEPTH)
  ) u_bht (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_idx_i   (fetch_pc[IDX_W+1:2]),
    .rd_ctr_o   (fetch_ctr),
    .we_i       (bht_we),
    .wr_idx_i   (ex_pc[IDX_W+1:2]),
    .wr_taken_i (cond_tk)
  );

  assign unused_pc_bits = ^{fetch_pc[XLEN-1:IDX_W+2], fetch_pc[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      redir_valid_q   <= 1'b0;
      redir_pc_q      <= '0;
      redir_rob_idx_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mispredict) begin
            state_q         <= HOLD;
            redir_valid_q   <= 1'b1;
            redir_pc_q      <= redir_pc_d;
            redir_rob_idx_q <= ex_rob_idx;
          end
        end
        HOLD: begin
          // Once accepted any new mispredict wins; otherwise only a strictly older one.
          if (mispredict && (handshake || (new_age < pend_age))) begin
            state_q         <= HOLD;
            redir_valid_q   <= 1'b1;
            redir_pc_q      <= redir_pc_d;
            redir_rob_idx_q <= ex_rob_idx;
          end else if (handshake) begin
            state_q       <= IDLE;
            redir_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q       <= IDLE;
          redir_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign fetch_pred_tk = fetch_ctr[1];
  assign redir_valid   = redir_valid_q;
  assign redir_pc      = redir_pc_q;
  assign redir_rob_idx = redir_rob_idx_q;
  assign if_id_flush   = handshake;

`ifdef BRU_STATS_EN
  logic [31:0] stat_branches_q;
  logic [31:0] stat_mispredicts_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      if (is_ctl) stat_branches_q <= stat_branches_q + 32'd1;
      if (mispredict) stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: a behavioural model queues expected
// per-cycle outputs and redirects; a negedge monitor pops and compares them.
module tb_branch_resolve_unit;

  localparam int XLEN  = 32;
  localparam int DEPTH = 64;
  localparam int RW    = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [XLEN-1:0] fetch_pc = '0;
  logic            fetch_pred_tk;
  logic            ex_valid = 1'b0, ex_jump = 1'b0, ex_branch = 1'b0;
  logic [2:0]      ex_funct3 = '0;
  logic            ex_zero = 1'b0, ex_neg = 1'b0, ex_carry = 1'b0;
  logic [XLEN-1:0] ex_alu_result = '0, ex_pc = '0, ex_imm = '0, ex_pred_tgt = '0;
  logic            ex_pred_tk = 1'b0;
  logic [RW-1:0]   ex_rob_idx = '0, rob_head = '0;
  logic            redir_valid;
  logic            redir_ready = 1'b0;
  logic [XLEN-1:0] redir_pc;
  logic [RW-1:0]   redir_rob_idx;
  logic            if_id_flush;
`ifdef BRU_STATS_EN
  logic [31:0]     stat_branches, stat_mispredicts;
`endif

  branch_resolve_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .ROB_IDX_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_pc(fetch_pc), .fetch_pred_tk(fetch_pred_tk),
    .ex_valid(ex_valid), .ex_jump(ex_jump), .ex_branch(ex_branch), .ex_funct3(ex_funct3),
    .ex_zero(ex_zero), .ex_neg(ex_neg), .ex_carry(ex_carry), .ex_alu_result(ex_alu_result),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_pred_tk(ex_pred_tk), .ex_pred_tgt(ex_pred_tgt),
    .ex_rob_idx(ex_rob_idx), .rob_head(rob_head), .redir_valid(redir_valid),
    .redir_ready(redir_ready), .redir_pc(redir_pc), .redir_rob_idx(redir_rob_idx),
    .if_id_flush(if_id_flush)
`ifdef BRU_STATS_EN
    , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid, jump, branch;
    logic [2:0]  f3;
    logic        zero, neg, carry;
    logic [31:0] alu, pc, imm, predTgt;
    logic        predTk;
    logic [4:0]  rob, head;
    logic        ready;
    logic [31:0] fpc;
  } stim_t;

  typedef struct { logic valid; logic pred; } cyc_t;
  typedef struct { logic [31:0] pc; logic [4:0] rob; } redir_t;

  cyc_t   cycQ[$];
  redir_t redirQ[$];
  int     tests = 0;
  int     fails = 0;
  int     bht[DEPTH];
  logic   pendV;
  logic [31:0] pendPc;
  logic [4:0]  pendRob;
  int     expBranches, expMispredicts;
  logic   monEn = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int idxOf(input logic [31:0] pc);
    return int'((pc >> 2) % DEPTH);
  endfunction

  function automatic int ageOf(input logic [4:0] x, input logic [4:0] head);
    return (int'(x) - int'(head) + 32) % 32;
  endfunction

  function automatic stim_t idle(input logic [31:0] fpc, input logic ready);
    stim_t s;
    s = '{valid: 1'b0, jump: 1'b0, branch: 1'b0, f3: 3'b0, zero: 1'b0, neg: 1'b0,
          carry: 1'b0, alu: 32'h0, pc: 32'h0, imm: 32'h0, predTgt: 32'h0, predTk: 1'b0,
          rob: 5'h0, head: 5'h0, ready: ready, fpc: fpc};
    return s;
  endfunction

  function automatic stim_t branchOp(input logic [31:0] pc, input logic [31:0] imm,
                                     input logic [2:0] f3, input logic zero,
                                     input logic predTk, input logic [4:0] rob,
                                     input logic [4:0] head, input logic ready);
    stim_t s;
    s = idle(pc, ready);
    s.valid = 1'b1; s.branch = 1'b1; s.f3 = f3; s.zero = zero; s.pc = pc; s.imm = imm;
    s.predTk = predTk; s.predTgt = pc + imm; s.rob = rob; s.head = head;
    return s;
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < DEPTH; i++) bht[i] = 1;
    pendV = 1'b0; pendPc = '0; pendRob = '0;
    expBranches = 0; expMispredicts = 0;
    cycQ.delete(); redirQ.delete();
  endfunction

  // Drive one cycle of inputs, predict its outcome from the resolve rules, then advance.
  task automatic applyStimulus(input stim_t s);
    cyc_t c; redir_t r; logic tk; logic mis; logic [31:0] tgt; int wi;
    ex_valid = s.valid; ex_jump = s.jump; ex_branch = s.branch; ex_funct3 = s.f3;
    ex_zero = s.zero; ex_neg = s.neg; ex_carry = s.carry; ex_alu_result = s.alu;
    ex_pc = s.pc; ex_imm = s.imm; ex_pred_tk = s.predTk; ex_pred_tgt = s.predTgt;
    ex_rob_idx = s.rob; rob_head = s.head; redir_ready = s.ready; fetch_pc = s.fpc;
    c.valid = pendV;
    c.pred = (bht[idxOf(s.fpc)] >= 2);
    cycQ.push_back(c);
    if (pendV && s.ready) begin
      r.pc = pendPc; r.rob = pendRob;
      redirQ.push_back(r);
      pendV = 1'b0;
    end
    if (s.valid && (s.jump || s.branch)) begin
      expBranches++;
      tk = 1'b0;
      if (s.jump) begin
        tk = 1'b1;
        tgt = s.alu & 32'hFFFF_FFFE;
      end else begin
        tgt = s.pc + s.imm;
        case (s.f3)
          3'b000: tk = s.zero;
          3'b001: tk = !s.zero;
          3'b100: tk = s.neg;
          3'b101: tk = !s.neg;
          3'b110: tk = s.carry;
          3'b111: tk = !s.carry;
          default: tk = 1'b0;
        endcase
        wi = idxOf(s.pc);
        bht[wi] = tk ? ((bht[wi] == 3) ? 3 : bht[wi] + 1) : ((bht[wi] == 0) ? 0 : bht[wi] - 1);
      end
      mis = (tk != s.predTk) || (tk && (tgt != s.predTgt));
      if (mis) begin
        expMispredicts++;
        if (!pendV || (ageOf(s.rob, s.head) < ageOf(pendRob, s.head))) begin
          pendV = 1'b1;
          pendPc = tk ? tgt : s.pc + 32'd4;
          pendRob = s.rob;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    cyc_t c; redir_t r;
    if (rst_n && monEn) begin
      if (cycQ.size() == 0) begin
        checkOutput("cycle_queue_underrun", 32'd0, 32'd1);
      end else begin
        c = cycQ.pop_front();
        checkOutput("redir_valid", {31'd0, redir_valid}, {31'd0, c.valid});
        checkOutput("fetch_pred_tk", {31'd0, fetch_pred_tk}, {31'd0, c.pred});
      end
      if (redir_valid && redir_ready) begin
        checkOutput("if_id_flush_on_handshake", {31'd0, if_id_flush}, 32'd1);
        if (redirQ.size() == 0) begin
          checkOutput("unexpected_redirect", 32'd0, 32'd1);
        end else begin
          r = redirQ.pop_front();
          checkOutput("redir_pc", redir_pc, r.pc);
          checkOutput("redir_rob_idx", {27'd0, redir_rob_idx}, {27'd0, r.rob});
        end
      end else begin
        checkOutput("if_id_flush_quiet", {31'd0, if_id_flush}, 32'd0);
      end
    end
  end

  task automatic applyReset();
    monEn = 1'b0;
    rst_n = 1'b0;
    #2;
    checkOutput("reset_redir_valid", {31'd0, redir_valid}, 32'd0);
    checkOutput("reset_if_id_flush", {31'd0, if_id_flush}, 32'd0);
    checkOutput("reset_redir_pc", redir_pc, 32'd0);
    checkOutput("reset_redir_rob_idx", {27'd0, redir_rob_idx}, 32'd0);
`ifdef BRU_STATS_EN
    checkOutput("reset_stat_branches", stat_branches, 32'd0);
    checkOutput("reset_stat_mispredicts", stat_mispredicts, 32'd0);
`endif
    modelReset();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    monEn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    stim_t s;
    modelReset();
    #2;
    fetch_pc = 32'h100;
    #1;
    checkOutput("reset_fetch_pred_0x100", {31'd0, fetch_pred_tk}, 32'd0);
    applyReset();

    // Mispredicted taken BEQ, accepted the cycle after it appears.
    applyStimulus(idle(32'h100, 1'b0));
    s = branchOp(32'h100, 32'h20, 3'b000, 1'b1, 1'b0, 5'd4, 5'd0, 1'b0);
    applyStimulus(s);
    applyStimulus(idle(32'h100, 1'b1));
    applyStimulus(idle(32'h100, 1'b1));

    // JALR with low bit set in the computed target: correctly predicted.
    s = idle(32'h0, 1'b1);
    s.valid = 1'b1; s.jump = 1'b1; s.alu = 32'h2001; s.pc = 32'h1000;
    s.predTk = 1'b1; s.predTgt = 32'h2000;
    applyStimulus(s);
    applyStimulus(idle(32'h0, 1'b1));

    // Age ordering across the ROB wrap with fetch stalled.
    applyStimulus(branchOp(32'h200, 32'h8, 3'b000, 1'b1, 1'b0, 5'd2, 5'd30, 1'b0));
    applyStimulus(branchOp(32'h300, 32'h8, 3'b000, 1'b1, 1'b0, 5'd31, 5'd30, 1'b0));
    applyStimulus(branchOp(32'h400, 32'h8, 3'b000, 1'b1, 1'b0, 5'd3, 5'd30, 1'b0));
    applyStimulus(idle(32'h300, 1'b0));
    applyStimulus(idle(32'h300, 1'b1));
    applyStimulus(idle(32'h300, 1'b1));

    // Saturation both ways at pc 0x40, probed by a single reversal.
    for (int i = 0; i < 4; i++) applyStimulus(branchOp(32'h40, 32'h10, 3'b001, 1'b0, 1'b1, 5'd0, 5'd0, 1'b1));
    applyStimulus(idle(32'h40, 1'b1));
    applyStimulus(branchOp(32'h40, 32'h10, 3'b001, 1'b1, 1'b1, 5'd0, 5'd0, 1'b1));
    applyStimulus(idle(32'h40, 1'b1));
    for (int i = 0; i < 4; i++) applyStimulus(branchOp(32'h40, 32'h10, 3'b001, 1'b1, 1'b0, 5'd0, 5'd0, 1'b1));
    applyStimulus(idle(32'h40, 1'b1));
    applyStimulus(branchOp(32'h40, 32'h10, 3'b001, 1'b0, 1'b0, 5'd0, 5'd0, 1'b1));
    applyStimulus(idle(32'h40, 1'b1));
    applyStimulus(idle(32'h40, 1'b1));

    // Randomised traffic with aliasing PCs and random fetch back-pressure.
    for (int n = 0; n < 600; n++) begin
      s = idle(32'($urandom_range(0, 127)) << 2, 1'($urandom_range(0, 1)));
      s.valid = ($urandom_range(0, 9) < 7);
      s.jump = ($urandom_range(0, 4) == 0);
      s.branch = ($urandom_range(0, 4) != 0);
      s.f3 = 3'($urandom_range(0, 7));
      s.zero = 1'($urandom_range(0, 1));
      s.neg = 1'($urandom_range(0, 1));
      s.carry = 1'($urandom_range(0, 1));
      s.pc = 32'($urandom_range(0, 127)) << 2;
      s.imm = (32'($urandom_range(0, 63)) << 2) - 32'd128;
      s.alu = $urandom;
      s.predTk = 1'($urandom_range(0, 1));
      s.predTgt = $urandom_range(0, 1) ? (s.jump ? (s.alu & 32'hFFFF_FFFE) : s.pc + s.imm) : $urandom;
      s.rob = 5'($urandom_range(0, 31));
      s.head = 5'($urandom_range(0, 31));
      applyStimulus(s);
    end

    // Drain and confirm the counters before pulling reset mid-HOLD.
    applyStimulus(idle(32'h0, 1'b1));
    applyStimulus(idle(32'h0, 1'b1));
`ifdef BRU_STATS_EN
    checkOutput("stat_branches", stat_branches, 32'(expBranches));
    checkOutput("stat_mispredicts", stat_mispredicts, 32'(expMispredicts));
`endif
    applyStimulus(branchOp(32'h500, 32'h40, 3'b000, 1'b1, 1'b0, 5'd7, 5'd0, 1'b0));
    applyStimulus(idle(32'h500, 1'b0));
    checkOutput("redirQ_empty_before_reset", 32'(redirQ.size()), 32'd0);
    applyReset();
    applyStimulus(idle(32'h100, 1'b0));
    applyStimulus(idle(32'h100, 1'b1));
    monEn = 1'b0;

    @(negedge clk);
    #1;
    checkOutput("redirQ_drained", 32'(redirQ.size()), 32'd0);
    checkOutput("cycQ_drained", 32'(cycQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
